// File: rtl/mips_timer_dev.sv
// Memory-mapped countdown timer on the CPU data bus.
// CTRL/PRESET/COUNT registers plus a level interrupt to the CPU.
module mips_timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  state_t      state_q;
  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        flag_q;

  logic        sel;
  logic        wr;
  logic [1:0]  off;
  logic        hit_ctrl;
  logic        hit_pre;
  logic        hit_cnt;
  logic        hit_ack;
  logic        wr_ctrl;
  logic        wr_pre;
  logic        wr_ack;
  logic        wr_cfg;
  logic [3:0]  ctrl_wr;
  logic [31:0] preset_wr;
  logic        en;
  logic        auto_rl;
  logic        im;
  logic        unused_addr;

  assign sel = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr  = sel & (|byteen);
  assign off = addr[3:2];

  assign hit_ctrl = sel & (off == 2'd0);
  assign hit_pre  = sel & (off == 2'd1);
  assign hit_cnt  = sel & (off == 2'd2);
  assign hit_ack  = sel & (off == 2'd3);

  assign wr_ctrl = wr & hit_ctrl;
  assign wr_pre  = wr & hit_pre;
  assign wr_ack  = wr & hit_ack;
  assign wr_cfg  = wr_ctrl | wr_pre;

  // word-aligned bus; the byte offset carries no meaning here
  assign unused_addr = ^addr[1:0];

  assign en      = ctrl_q[0];
  assign auto_rl = (ctrl_q[2:1] == 2'b01);
  assign im      = ctrl_q[3];

  assign ctrl_wr = byteen[0] ? wdata[3:0] : ctrl_q;

  always_comb begin
    preset_wr = preset_q;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) begin
        preset_wr[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    unique case (1'b1)
      hit_ctrl: rdata = {28'd0, ctrl_q};
      hit_pre:  rdata = preset_q;
      hit_cnt:  rdata = count_q;
      default:  rdata = 32'd0;
    endcase
  end

  assign irq = flag_q & im;

  // a config write restarts the sequence; it always wins over the FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else if (wr_cfg) begin
      if (wr_ctrl) begin
        ctrl_q <= ctrl_wr;
      end
      if (wr_pre) begin
        preset_q <= preset_wr;
      end
      state_q <= IDLE;
      flag_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          count_q <= preset_q;
          state_q <= CNT;
        end
        CNT: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (count_q <= 32'd1) begin
            count_q <= 32'd0;
            state_q <= INT;
          end else begin
            count_q <= count_q - 32'd1;
          end
        end
        INT: begin
          flag_q <= 1'b1;
          if (!auto_rl) begin
            ctrl_q[0] <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (wr_ack) begin
        flag_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_timer_dev.sv
// Bench for mips_timer_dev: vector table, hand sequences,
// and randomized traffic against an elapsed-time model.
module tb_mips_timer_dev;

  localparam logic [31:0] T = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        irq;

  int n_run;
  int n_fail;

  mips_timer_dev #(.BASE_ADDR(T)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .byteen (byteen),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] ra;
    logic [31:0] er;
    logic        ei;
    string       nm;
  } vec_t;

  vec_t vq[$];

  // model: elapsed edges since arming decide everything
  logic [3:0]  m_ctrl;
  logic [31:0] m_pre;
  logic [31:0] m_cnt;
  logic        m_flag;
  longint      m_t;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != T[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_pre;
      2'd2:    return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_edge(input logic rst, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    logic   s;
    logic   w;
    longint m;
    s = (a[31:4] == T[31:4]);
    w = s && (be != 4'd0);
    if (!rst) begin
      m_ctrl = 4'd0;
      m_pre  = 32'd0;
      m_cnt  = 32'd0;
      m_flag = 1'b0;
      m_t    = 0;
    end else if (w && (a[3:2] == 2'd0 || a[3:2] == 2'd1)) begin
      if (a[3:2] == 2'd0 && be[0]) m_ctrl = d[3:0];
      if (a[3:2] == 2'd1) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_pre[8*i +: 8] = d[8*i +: 8];
      end
      m_flag = 1'b0;
      m_t    = 0;
    end else begin
      if (m_ctrl[0]) begin
        m_t = m_t + 1;
        m = (m_pre == 0) ? 1 : longint'(m_pre);
        if (m_t >= 2 && m_t <= 2 + m) begin
          if (longint'(m_pre) > m_t - 2)
            m_cnt = 32'(longint'(m_pre) - (m_t - 2));
          else
            m_cnt = 32'd0;
        end
        if (m_t == 3 + m) begin
          m_flag = 1'b1;
          m_t    = 0;
          if (m_ctrl[2:1] != 2'b01) m_ctrl[0] = 1'b0;
        end
      end
      if (w && a[3:2] == 2'd3) m_flag = 1'b0;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] a,
                       input logic [31:0] er, input logic ei);
    addr   = a;
    byteen = 4'd0;
    #1;
    n_run++;
    if (rdata !== er || irq !== ei) begin
      n_fail++;
      $display("FAIL %s addr=%h rdata=%h irq=%b expected rdata=%h irq=%b",
               nm, a, rdata, irq, er, ei);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    reset  = rst;
    addr   = a;
    wdata  = d;
    byteen = be;
    @(posedge clk);
    #1;
    reset  = 1'b1;
    byteen = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, T + 32'h10, 32'd0, 4'd0);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    step(1'b1, a, d, be);
  endtask

  function automatic void add(input logic rst, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be,
                              input logic [31:0] ra, input logic [31:0] er,
                              input logic ei, input string nm);
    vec_t v;
    v.rst = rst; v.a = a; v.d = d; v.be = be;
    v.ra = ra; v.er = er; v.ei = ei; v.nm = nm;
    vq.push_back(v);
  endfunction

  function automatic void idl(input logic [31:0] ra, input logic [31:0] er,
                              input logic ei, input string nm);
    add(1'b1, ra, 32'd0, 4'd0, ra, er, ei, nm);
  endfunction

  initial begin
    logic        rr;
    logic [31:0] ra;
    logic [31:0] rd;
    logic [3:0]  rb;
    int          r;

    n_run  = 0;
    n_fail = 0;
    reset  = 1'b0;
    addr   = 32'd0;
    wdata  = 32'd0;
    byteen = 4'd0;

    add(1'b0, T, 0, 4'd0, T + 0,  0, 1'b0, "rst_ctrl");
    add(1'b0, T, 0, 4'd0, T + 4,  0, 1'b0, "rst_pre");
    add(1'b0, T, 0, 4'd0, T + 8,  0, 1'b0, "rst_cnt");
    add(1'b0, T, 0, 4'd0, T + 12, 0, 1'b0, "rst_ack");
    add(1'b1, T + 4, 5, 4'hF, T + 4, 5, 1'b0, "os_pre");
    add(1'b1, T + 0, 9, 4'hF, T + 0, 9, 1'b0, "os_e0");
    idl(T + 8, 0, 1'b0, "os_e1");
    idl(T + 8, 5, 1'b0, "os_e2");
    idl(T + 8, 4, 1'b0, "os_e3");
    idl(T + 8, 3, 1'b0, "os_e4");
    idl(T + 8, 2, 1'b0, "os_e5");
    idl(T + 8, 1, 1'b0, "os_e6");
    idl(T + 8, 0, 1'b0, "os_e7");
    idl(T + 0, 8, 1'b1, "os_e8");
    add(1'b1, T + 12, 0, 4'h1, T + 8, 0, 1'b0, "os_ack");
    add(1'b1, T + 8, 32'h7B, 4'hF, T + 8, 0, 1'b0, "cnt_ro");
    idl(T + 32'h10, 0, 1'b0, "unsel");
    add(1'b1, T + 4, 2, 4'hF, T + 4, 2, 1'b0, "im_pre");
    add(1'b1, T + 0, 1, 4'hF, T + 0, 1, 1'b0, "im_e0");
    idl(T + 8, 0, 1'b0, "im_e1");
    idl(T + 8, 2, 1'b0, "im_e2");
    idl(T + 8, 1, 1'b0, "im_e3");
    idl(T + 8, 0, 1'b0, "im_e4");
    idl(T + 0, 0, 1'b0, "im_e5");
    add(1'b1, T + 0, 8, 4'hF, T + 0, 8, 1'b0, "im_clr");
    add(1'b1, T + 4, 6, 4'hF, T + 4, 6, 1'b0, "mid_pre");
    add(1'b1, T + 0, 9, 4'hF, T + 0, 9, 1'b0, "mid_e0");
    idl(T + 8, 0, 1'b0, "mid_e1");
    idl(T + 8, 6, 1'b0, "mid_e2");
    idl(T + 8, 5, 1'b0, "mid_e3");
    idl(T + 8, 4, 1'b0, "mid_e4");
    idl(T + 8, 3, 1'b0, "mid_e5");
    add(1'b1, T + 0, 0, 4'h1, T + 8, 3, 1'b0, "mid_stop");
    idl(T + 0, 0, 1'b0, "mid_ctrl");
    idl(T + 8, 3, 1'b0, "mid_hold1");
    idl(T + 8, 3, 1'b0, "mid_hold2");

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].a, vq[i].d, vq[i].be);
      check(vq[i].nm, vq[i].ra, vq[i].er, vq[i].ei);
    end

    // auto-reload with sticky flag, ACK, second interrupt
    bus_wr(T + 4, 5, 4'hF);
    bus_wr(T + 0, 32'hB, 4'hF);
    idle(7);
    check("ar_e7", T + 8, 0, 1'b0);
    idle(1);
    check("ar_e8", T + 0, 32'hB, 1'b1);
    idle(2);
    check("ar_reload", T + 8, 5, 1'b1);
    bus_wr(T + 12, 0, 4'h8);
    check("ar_ack", T + 8, 4, 1'b0);
    idle(4);
    check("ar_e15", T + 8, 0, 1'b0);
    idle(1);
    check("ar_int2", T + 8, 0, 1'b1);

    // PRESET=0 counts as one
    bus_wr(T + 0, 0, 4'hF);
    check("p0_off", T + 0, 0, 1'b0);
    bus_wr(T + 4, 0, 4'hF);
    bus_wr(T + 0, 9, 4'hF);
    idle(3);
    check("p0_e3", T + 8, 0, 1'b0);
    idle(1);
    check("p0_e4", T + 0, 8, 1'b1);

    // reset in the middle of an auto-reload run
    bus_wr(T + 4, 2, 4'hF);
    bus_wr(T + 0, 32'hB, 4'hF);
    idle(7);
    check("rm_pre", T + 8, 2, 1'b1);
    step(1'b0, T + 32'h10, 0, 4'd0);
    reset = 1'b0;
    check("rm_ctrl", T + 0, 0, 1'b0);
    check("rm_pre2", T + 4, 0, 1'b0);
    check("rm_cnt", T + 8, 0, 1'b0);
    reset = 1'b1;
    idle(2);
    check("rm_after", T + 8, 0, 1'b0);

    // randomized traffic against the model
    step(1'b0, T + 32'h10, 0, 4'd0);
    m_edge(1'b0, 0, 0, 4'd0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r  = $urandom_range(0, 99);
      rr = 1'b1;
      rb = 4'd0;
      rd = $urandom;
      ra = T + {26'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (r < 4) begin
        ra = T + {30'd0, 2'($urandom_range(0, 3))};
        rd = {$urandom_range(0, 3) == 0 ? 28'hABCDEF1 : 28'd0,
              4'($urandom_range(0, 15))};
        rb = 4'($urandom_range(1, 15));
      end else if (r < 7) begin
        ra = T + 4;
        rd = 32'($urandom_range(0, 7));
        rb = 4'($urandom_range(1, 15));
      end else if (r < 10) begin
        ra = T + 12;
        rb = 4'($urandom_range(1, 15));
      end else if (r < 12) begin
        ra = T + 8;
        rb = 4'hF;
      end else if (r < 14) begin
        ra = (r == 12) ? T + 32'h10 : 32'h0000_0004;
        rb = 4'hF;
      end else if (r < 15) begin
        rr = 1'b0;
      end
      reset  = rr;
      addr   = ra;
      wdata  = rd;
      byteen = rb;
      #1;
      n_run++;
      if (rdata !== m_read(ra) || irq !== (m_flag & m_ctrl[3])) begin
        n_fail++;
        $display("FAIL rnd%0d addr=%h rdata=%h irq=%b expected rdata=%h irq=%b",
                 c, ra, rdata, irq, m_read(ra), m_flag & m_ctrl[3]);
      end
      @(posedge clk);
      m_edge(rr, ra, rd, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
